mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
MEM-stage sequencer for the 5-stage RISC-V core. It takes the load/store controls held in the EX/MEM pipeline register and runs a variable-latency req/ack transaction to the data bus. While the transaction is outstanding it stalls the pipeline, so EX/MEM and the upstream stages hold. It also handles byte lanes, load extension, misalignment and bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles without ack before abort (must be >=1)
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
mem_read  in  1  EX/MEM MemRead
mem_write  in  1  EX/MEM MemWrite
funct3  in  3  instruction[14:12] from EX/MEM; 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  EX/MEM alu_result
wdata  in  32  EX/MEM write_data
bus_req  out  1  transaction request, registered
bus_we  out  1  1 = store
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ack  in  1  one-cycle completion strobe
bus_rdata  in  32  read word, valid with bus_ack
stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
load_data  out  32  extended load result for MEM/WB
load_valid  out  1  one-cycle strobe, load_data valid
misalign_err  out  1  one-cycle pulse, access not issued
timeout_err  out  1  one-cycle pulse, access aborted

Behaviour:
- Reset: state=IDLE. bus_req, bus_we, stall, load_valid, misalign_err and timeout_err = 0. bus_addr, bus_wdata, load_data = 0. bus_be = 0. Counter = 0. Reset mid-transaction drops bus_req immediately; the outstanding access is abandoned.
- access = mem_read | mem_write. If both are set, treat as a store.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- IDLE:
  - No access: stall=0.
  - Access and misaligned: stall=0, no bus request. misalign_err=1 next cycle. load_data=0 and load_valid=1 next cycle if it is a load. State stays IDLE.
  - Access and aligned: stall=1 in the same cycle. Latch we/addr/be/wdata/funct3/addr[1:0]. Next state BUSY, bus_req=1 from the next cycle. Counter=0.
- BUSY: stall=1, bus_req=1, bus outputs stable.
  - bus_ack=1: capture and extend bus_rdata, go DONE, bus_req=0 next cycle.
  - No ack: counter++. When counter reaches TIMEOUT_CYCLES-1 with no ack, go DONE with timeout flag set, load_data=0.
- DONE (one cycle): stall=0, so the pipeline advances and consumes the EX/MEM instruction. load_valid=1 for loads. timeout_err=1 if timed out. The DONE cycle never starts a new access. Next state IDLE.
- Minimum aligned-access latency is 3 cycles (IDLE, BUSY with ack, DONE), i.e. 2 stall cycles.
- Byte enables and store data:
  - B: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: be = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: be = 4'hF.
  - Loads drive be = 4'hF.
- Load extension: select lane by the latched addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
- bus_ack while not in BUSY is ignored.
- funct3 values other than the five listed are treated as W.

Decomposition:
- Shared package core_pkg: funct3 load/store encodings, the FSM state enum (IDLE, BUSY, DONE), and the NOP constant 32'h00000013.
- One sub-module, load_align, is natural: combinational lane select plus sign/zero extension (funct3, offset, rdata -> data). It is reused by the bench's reference model.

Test Plan:
- LW addr=0x100, bus_ack in the first BUSY cycle, rdata=0xDEADBEEF -> stall high 2 cycles, bus_addr=0x100, be=F, load_valid with load_data=0xDEADBEEF.
- LB addr=0x203, rdata=0x80112233 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SB addr=0x302, wdata=0x000000AB, ack after 4 cycles -> bus_we=1, be=4'b0100, bus_wdata=0xABABABAB, stall held 5 cycles, no load_valid.
- LW addr=0x401 -> misalign_err pulse, bus_req never asserted, stall never asserted.
- LW with no ack -> bus_req drops after 16 BUSY cycles, timeout_err and load_valid pulse, load_data=0.
- rst pulsed on the 2nd BUSY cycle -> bus_req and stall go low asynchronously. A following LH addr=0x10, rdata=0x0000F000 -> load_data=0xFFFFF000.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: encodings and helpers shared by the MEM-stage logic.
//   - funct3 load/store width encodings (B, H, W, BU, HU)
//   - FSM state enum for the MEM-stage sequencer (IDLE, BUSY, DONE)
//   - NOP instruction constant used for pipeline bubbles
//   - helpers for access size, misalignment, byte enables and store lanes
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Unlisted funct3 codes fall back to word accesses.
    function automatic size_t f3_size(input logic [2:0] f3);
        size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3_size(f3))
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Loads always fetch the whole word; stores enable only the written lanes.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off,
                                            input logic we);
        logic [3:0] be;
        if (!we) begin
            be = 4'hF;
        end else begin
            case (f3_size(f3))
                SZ_BYTE: be = 4'b0001 << off;
                SZ_HALF: be = 4'b0011 << off;
                default: be = 4'hF;
            endcase
        end
        return be;
    endfunction

    // Replicate the store operand across lanes so the enabled lane carries it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3_size(f3))
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// load_align: combinational lane select and sign/zero extension of a read word.
//   funct3 [2:0]  : load width/signedness (B, H, W, BU, HU; others act as W)
//   offset [1:0]  : byte offset of the access within the word
//   rdata  [31:0] : raw word from the data bus
//   data   [31:0] : extended load result
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/halfword, then extend according to funct3.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = rdata;

        case (offset)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase

        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end

        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data = {24'h000000, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_HU:   data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage sequencer running one req/ack data-bus access per
// EX/MEM load/store, stalling the pipeline while the access is outstanding.
//   clk, rst                  : clock, asynchronous active-high reset
//   mem_read, mem_write       : EX/MEM controls (both set = store)
//   funct3, addr, wdata       : access width, byte address, store operand
//   bus_req/we/addr/wdata/be  : registered bus request, held for the access
//   bus_ack, bus_rdata        : completion strobe and read word
//   stall                     : combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   load_data, load_valid     : extended load result and its one-cycle strobe
//   misalign_err, timeout_err : one-cycle error pulses
module mem_access_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       f3_r;
    logic [1:0]       off_r;
    logic             access_s;
    logic             misalign_s;
    logic             cnt_last_s;
    logic [31:0]      ext_data_s;

    // Decode the EX/MEM request and the timeout boundary.
    always_comb begin
        access_s   = mem_read | mem_write;
        misalign_s = is_misaligned(funct3, addr[1:0]);
        cnt_last_s = (cnt_r == CNT_LAST);
    end

    // Next state and stall; stall is forced low while reset is asserted so an
    // access held in EX/MEM cannot keep the pipeline frozen through a reset.
    always_comb begin
        state_nxt_s = state_r;
        stall       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s && !misalign_s && !rst) begin
                    stall       = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else begin
                    stall       = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (bus_ack || cnt_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            // DONE releases the pipeline for one cycle and never starts an access.
            ST_DONE: begin
                stall       = 1'b0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                stall       = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    load_align u_load_align (
        .funct3 (f3_r),
        .offset (off_r),
        .rdata  (bus_rdata),
        .data   (ext_data_s)
    );

    // Bus request, latched access fields, timeout counter and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0000_0000;
            bus_wdata    <= 32'h0000_0000;
            bus_be       <= 4'h0;
            f3_r         <= 3'b000;
            off_r        <= 2'b00;
            cnt_r        <= '0;
            load_data    <= 32'h0000_0000;
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            load_valid   <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (access_s && misalign_s) begin
                        misalign_err <= 1'b1;
                        if (!mem_write) begin
                            load_data  <= 32'h0000_0000;
                            load_valid <= 1'b1;
                        end
                    end else if (access_s) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_be    <= store_be(funct3, addr[1:0], mem_write);
                        bus_wdata <= store_data(funct3, wdata);
                        f3_r      <= funct3;
                        off_r     <= addr[1:0];
                        cnt_r     <= '0;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            load_data  <= ext_data_s;
                            load_valid <= 1'b1;
                        end
                    end else if (cnt_last_s) begin
                        bus_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (!bus_we) begin
                            load_data  <= 32'h0000_0000;
                            load_valid <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
// Each access is described at transaction level (kind, width, address,
// operand, ack cycle, read word); the expected per-cycle outputs follow from
// that description and are checked every cycle by one compare process.
module tb_mem_access_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misalign_err, timeout_err;

    int n_vec = 0;
    int n_err = 0;
    int n_stall = 0;
    int n_req = 0;
    int n_lv = 0;
    bit chk_en = 1'b0;

    logic        exp_stall, exp_req, exp_we, exp_lv, exp_mis, exp_tmo;
    logic [31:0] exp_addr, exp_wd, exp_ld;
    logic [3:0]  exp_be;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misalign_err(misalign_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input int off);
        return (off % acc_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input int off, input bit store);
        logic [3:0] mask;
        if (!store) return 4'hF;
        mask = 4'((1 << acc_bytes(f3)) - 1);
        return mask << off;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (acc_bytes(f3))
            1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        int          bits;
        logic [31:0] v;
        bits = 8 * acc_bytes(f3);
        if (bits == 32) return rd;
        v = (rd >> (8 * off)) & ((32'd1 << bits) - 32'd1);
        if (!f3[2] && v[bits-1]) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_lv = 1'b0;
        exp_mis = 1'b0; exp_tmo = 1'b0; exp_ld = 32'h0; exp_addr = 32'h0;
        exp_wd = 32'h0; exp_be = 4'h0;
    endtask

    // Compare DUT outputs against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (stall) n_stall++;
            if (bus_req) n_req++;
            if (load_valid) n_lv++;
            check("stall", {31'h0, stall}, {31'h0, exp_stall});
            check("bus_req", {31'h0, bus_req}, {31'h0, exp_req});
            check("load_valid", {31'h0, load_valid}, {31'h0, exp_lv});
            check("misalign_err", {31'h0, misalign_err}, {31'h0, exp_mis});
            check("timeout_err", {31'h0, timeout_err}, {31'h0, exp_tmo});
            if (exp_req) begin
                check("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
                check("bus_addr", bus_addr, exp_addr);
                check("bus_be", {28'h0, bus_be}, {28'h0, exp_be});
                if (exp_we) check("bus_wdata", bus_wdata, exp_wd);
            end
            if (exp_lv) check("load_data", load_data, exp_ld);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        step();
        mem_read = 1'b0; mem_write = 1'b0; bus_ack = ack; bus_rdata = 32'hA5A5_5A5A;
        set_idle_exp();
    endtask

    // One EX/MEM access; ack_at = BUSY cycle carrying bus_ack (0 = never).
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd_word);
        bit store, mis, tmo;
        int nbusy, off;
        store = wr;
        off   = int'(a[1:0]);
        mis   = m_mis(f3, off);
        tmo   = (ack_at == 0) || (ack_at > TMO);
        nbusy = tmo ? TMO : ack_at;
        n_stall = 0; n_req = 0; n_lv = 0;
        step();
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        set_idle_exp();
        exp_stall = !mis;
        if (mis) begin
            step();
            mem_read = 1'b0; mem_write = 1'b0;
            set_idle_exp();
            exp_mis = 1'b1; exp_lv = !store; exp_ld = 32'h0;
        end else begin
            for (int c = 1; c <= nbusy; c++) begin
                step();
                set_idle_exp();
                exp_stall = 1'b1; exp_req = 1'b1; exp_we = store;
                exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, off, store);
                exp_wd = m_wdata(f3, wd);
                bus_ack   = (c == ack_at);
                bus_rdata = (c == ack_at) ? rd_word : ~rd_word;
            end
            step();
            bus_ack = 1'b0;
            set_idle_exp();
            exp_lv = !store; exp_tmo = tmo;
            exp_ld = tmo ? 32'h0 : m_load(f3, off, rd_word);
        end
        idle(1'b0);
        settle();
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        set_idle_exp();

        // Model pinned to hand-computed values.
        check("pin_lw", m_load(3'b010, 0, 32'hDEADBEEF), 32'hDEADBEEF);
        check("pin_lb", m_load(3'b000, 3, 32'h80112233), 32'hFFFFFF80);
        check("pin_lbu", m_load(3'b100, 3, 32'h80112233), 32'h00000080);
        check("pin_lh", m_load(3'b001, 0, 32'h0000F000), 32'hFFFFF000);
        check("pin_sb_wd", m_wdata(3'b000, 32'h000000AB), 32'hABABABAB);
        check("pin_sb_be", {28'h0, m_be(3'b000, 2, 1'b1)}, 32'h4);

        #3;
        check("rst_req", {31'h0, bus_req}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_flags", {29'h0, load_valid, misalign_err, timeout_err}, 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_be", {28'h0, bus_be}, 32'h0);
        check("rst_ld", load_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // LW, ack in first BUSY cycle.
        run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        check("lw_stall_cycles", n_stall, 2);
        check("lw_lv_count", n_lv, 1);
        check("lw_data_lit", load_data, 32'hDEADBEEF);

        // LB / LBU at byte 3.
        run_txn(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 1, 32'h80112233);
        check("lb_data_lit", load_data, 32'hFFFFFF80);
        run_txn(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 2, 32'h80112233);
        check("lbu_data_lit", load_data, 32'h00000080);

        // SB with ack on the 4th BUSY cycle.
        run_txn(1'b0, 1'b1, 3'b000, 32'h302, 32'h000000AB, 4, 32'h0);
        check("sb_stall_cycles", n_stall, 5);
        check("sb_no_lv", n_lv, 0);

        // Misaligned LW: nothing issued.
        run_txn(1'b1, 1'b0, 3'b010, 32'h401, 32'h0, 1, 32'h0);
        check("mis_req_cycles", n_req, 0);
        check("mis_stall_cycles", n_stall, 0);

        // Unlisted funct3 acts as W; misaligned halfword load.
        run_txn(1'b1, 1'b0, 3'b011, 32'h502, 32'h0, 1, 32'h0);
        run_txn(1'b1, 1'b0, 3'b001, 32'h013, 32'h0, 1, 32'h0);

        // Read+write together is a store; SH upper half.
        run_txn(1'b1, 1'b1, 3'b001, 32'h602, 32'h00001234, 2, 32'hFFFFFFFF);
        check("sh_no_lv", n_lv, 0);
        run_txn(1'b0, 1'b1, 3'b010, 32'h700, 32'hCAFEF00D, 1, 32'h0);
        run_txn(1'b1, 1'b0, 3'b101, 32'h012, 32'h0, 3, 32'h8765ABCD);
        check("lhu_data_lit", load_data, 32'h00008765);

        // Stray ack while idle is ignored.
        n_lv = 0;
        idle(1'b1);
        idle(1'b0);
        settle();
        check("stray_ack_no_lv", n_lv, 0);

        // Timeout: LW with no ack.
        run_txn(1'b1, 1'b0, 3'b010, 32'h900, 32'h0, 0, 32'h0);
        check("tmo_req_cycles", n_req, TMO);
        check("tmo_stall_cycles", n_stall, TMO + 1);
        check("tmo_lv_count", n_lv, 1);

        // Reset on the 2nd BUSY cycle, then LH.
        step();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h800;
        set_idle_exp(); exp_stall = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            step();
            set_idle_exp();
            exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
            exp_addr = 32'h800; exp_be = 4'hF;
        end
        #1;
        rst = 1'b1;
        set_idle_exp();
        #1;
        check("async_rst_req", {31'h0, bus_req}, 32'h0);
        check("async_rst_stall", {31'h0, stall}, 32'h0);
        settle();
        mem_read = 1'b0;
        rst = 1'b0;
        run_txn(1'b1, 1'b0, 3'b001, 32'h010, 32'h0, 1, 32'h0000F000);
        check("lh_after_rst_lit", load_data, 32'hFFFFF000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
